// File: rtl/mem_defs.sv
// Shared definitions for the data memory arbiter: access width codes and
// the arbiter ownership states.
package mem_defs;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    typedef enum logic {
        S_PIPE = 1'b0,
        S_LOAD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_mux.sv
// Steers one requester's access fields onto the data memory port.
// With no grant the port is parked: enables low, address and data zero.
module mem_port_mux
    import mem_defs::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          en_i,
    input  logic          sel_l_i,
    input  logic          p_req_i,
    input  logic          p_write_i,
    input  logic [AW-1:0] p_addr_i,
    input  logic [DW-1:0] p_wdata_i,
    input  logic [1:0]    p_width_i,
    input  logic          l_req_i,
    input  logic          l_write_i,
    input  logic [AW-1:0] l_addr_i,
    input  logic [DW-1:0] l_wdata_i,
    input  logic [1:0]    l_width_i,
    output logic          r_en_o,
    output logic          w_en_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic [1:0]    width_o
);

    // Select the granted side, or park the port when nobody is granted.
    always_comb begin
        r_en_o  = 1'b0;
        w_en_o  = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        width_o = WIDTH_WORD;
        if (en_i) begin
            if (sel_l_i) begin
                r_en_o  = l_req_i & ~l_write_i;
                w_en_o  = l_req_i & l_write_i;
                addr_o  = l_addr_i;
                wdata_o = l_wdata_i;
                width_o = l_width_i;
            end else begin
                r_en_o  = p_req_i & ~p_write_i;
                w_en_o  = p_req_i & p_write_i;
                addr_o  = p_addr_i;
                wdata_o = p_wdata_i;
                width_o = p_width_i;
            end
        end else begin
            r_en_o  = 1'b0;
            w_en_o  = 1'b0;
            addr_o  = '0;
            wdata_o = '0;
            width_o = WIDTH_WORD;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data memory between the pipeline memory stage and the loader.
// Pipeline wins by default; a bounded wait count forces a loader grant.
module data_mem_arbiter
    import mem_defs::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          P_Req,
    input  logic          P_Write,
    input  logic [AW-1:0] P_Addr,
    input  logic [DW-1:0] P_WData,
    input  logic [1:0]    P_Width,
    output logic [DW-1:0] P_RData,
    output logic          P_Stall,
    input  logic          L_Req,
    input  logic          L_Write,
    input  logic          L_Lock,
    input  logic [AW-1:0] L_Addr,
    input  logic [DW-1:0] L_WData,
    input  logic [1:0]    L_Width,
    output logic          L_Ack,
    output logic [DW-1:0] L_RData,
    output logic          L_RValid,
    output logic          M_R_Enable,
    output logic          M_W_Enable,
    output logic [AW-1:0] M_Addr,
    output logic [DW-1:0] M_WData,
    output logic [1:0]    M_R_Width,
    output logic [1:0]    M_W_Width,
    input  logic [DW-1:0] M_RData
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
    localparam logic [WCW-1:0] WAIT_SAT  = {WCW{1'b1}};

    arb_state_t     state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [DW-1:0]  l_rdata_q;
    logic           l_rvalid_q;
    logic           grant_p_s, grant_l_s, stall_raw_s;
    logic           mem_en_s, l_ack_s, l_rd_ack_s;
    logic [1:0]     mem_width_s;

    // Grant decision from the registered owner and this cycle's requests.
    always_comb begin
        grant_p_s   = 1'b0;
        grant_l_s   = 1'b0;
        stall_raw_s = 1'b0;
        case (state_q)
            S_PIPE: begin
                grant_p_s   = P_Req;
                grant_l_s   = ~P_Req & L_Req;
                stall_raw_s = 1'b0;
            end
            S_LOAD: begin
                grant_p_s   = 1'b0;
                grant_l_s   = L_Req;
                stall_raw_s = P_Req;
            end
            default: begin
                grant_p_s   = 1'b0;
                grant_l_s   = 1'b0;
                stall_raw_s = 1'b0;
            end
        endcase
    end

    // Reset_n gates the handshakes directly so nothing escapes during reset.
    assign mem_en_s   = Reset_n & (grant_p_s | grant_l_s);
    assign l_ack_s    = Reset_n & grant_l_s;
    assign l_rd_ack_s = l_ack_s & ~L_Write;
    assign P_Stall    = Reset_n & stall_raw_s;
    assign L_Ack      = l_ack_s;
    assign P_RData    = M_RData;
    assign L_RData    = l_rdata_q;
    assign L_RValid   = l_rvalid_q;
    assign M_R_Width  = mem_width_s;
    assign M_W_Width  = mem_width_s;

    mem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .en_i      (mem_en_s),
        .sel_l_i   (grant_l_s),
        .p_req_i   (P_Req),
        .p_write_i (P_Write),
        .p_addr_i  (P_Addr),
        .p_wdata_i (P_WData),
        .p_width_i (P_Width),
        .l_req_i   (L_Req),
        .l_write_i (L_Write),
        .l_addr_i  (L_Addr),
        .l_wdata_i (L_WData),
        .l_width_i (L_Width),
        .r_en_o    (M_R_Enable),
        .w_en_o    (M_W_Enable),
        .addr_o    (M_Addr),
        .wdata_o   (M_WData),
        .width_o   (mem_width_s)
    );

    // Ownership and starvation counter; the last contended loss hands over.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_PIPE: begin
                if (P_Req & L_Req) begin
                    if (wait_q >= WAIT_LAST) begin
                        state_d = S_LOAD;
                        wait_d  = '0;
                    end else if (wait_q != WAIT_SAT) begin
                        state_d = S_PIPE;
                        wait_d  = wait_q + WCW'(1);
                    end else begin
                        state_d = S_PIPE;
                        wait_d  = wait_q;
                    end
                end else begin
                    state_d = S_PIPE;
                    wait_d  = '0;
                end
            end
            S_LOAD: begin
                state_d = (L_Req & L_Lock) ? S_LOAD : S_PIPE;
                wait_d  = '0;
            end
            default: begin
                state_d = S_PIPE;
                wait_d  = '0;
            end
        endcase
    end

    // State, wait counter and loader read-return registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_PIPE;
            wait_q     <= '0;
            l_rdata_q  <= '0;
            l_rvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (l_rd_ack_s) begin
                l_rdata_q  <= M_RData;
                l_rvalid_q <= 1'b1;
            end else begin
                l_rdata_q  <= l_rdata_q;
                l_rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, a reset
// mid-burst sequence and randomized traffic against a cycle-level model.
module tb_data_mem_arbiter;
    import mem_defs::*;

    localparam int MAX_WAIT = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          P_Req, P_Write, L_Req, L_Write, L_Lock;
    logic [AW-1:0] P_Addr, L_Addr;
    logic [DW-1:0] P_WData, L_WData;
    logic [1:0]    P_Width, L_Width;
    logic [DW-1:0] P_RData, L_RData, M_RData, M_WData;
    logic          P_Stall, L_Ack, L_RValid, M_R_Enable, M_W_Enable;
    logic [AW-1:0] M_Addr;
    logic [1:0]    M_R_Width, M_W_Width;

    data_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .P_Req(P_Req), .P_Write(P_Write), .P_Addr(P_Addr), .P_WData(P_WData),
        .P_Width(P_Width), .P_RData(P_RData), .P_Stall(P_Stall),
        .L_Req(L_Req), .L_Write(L_Write), .L_Lock(L_Lock), .L_Addr(L_Addr),
        .L_WData(L_WData), .L_Width(L_Width), .L_Ack(L_Ack), .L_RData(L_RData),
        .L_RValid(L_RValid), .M_R_Enable(M_R_Enable), .M_W_Enable(M_W_Enable),
        .M_Addr(M_Addr), .M_WData(M_WData), .M_R_Width(M_R_Width),
        .M_W_Width(M_W_Width), .M_RData(M_RData)
    );

    always #5 Clock = ~Clock;

    // Data memory macro stand-in: combinational read, write on the edge.
    logic [31:0] mem [0:255];
    assign M_RData = mem[M_Addr[9:2]];
    always @(posedge Clock) begin
        if (M_W_Enable) begin
            case (M_W_Width)
                WIDTH_BYTE: mem[M_Addr[9:2]][{M_Addr[1:0], 3'b000} +: 8]  <= M_WData[7:0];
                WIDTH_HALF: mem[M_Addr[9:2]][{M_Addr[1], 4'b0000} +: 16] <= M_WData[15:0];
                default:    mem[M_Addr[9:2]] <= M_WData;
            endcase
        end
    end

    typedef struct {
        logic        p_req, p_write;
        logic [31:0] p_addr, p_wdata;
        logic [1:0]  p_width;
        logic        l_req, l_write, l_lock;
        logic [31:0] l_addr, l_wdata;
        logic [1:0]  l_width;
        logic        chk;
        logic        e_stall, e_ack, e_mre, e_mwe;
        logic [31:0] e_addr;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: loader losses counted up to MAX_WAIT, then a forced turn.
    bit          m_forced;
    int          m_losses;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_forced = 1'b0;
        m_losses = 0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
    endtask

    function automatic vec_t mk(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                                input logic lr, input logic lw, input logic lk, input logic [31:0] la,
                                input logic [31:0] ld, input logic [1:0] lwid,
                                input logic es, input logic ea, input logic er, input logic ew,
                                input logic [31:0] eaddr, input logic erv, input logic [31:0] erd);
        vec_t v;
        v.p_req = pr; v.p_write = pw; v.p_addr = pa; v.p_wdata = pd; v.p_width = WIDTH_WORD;
        v.l_req = lr; v.l_write = lw; v.l_lock = lk; v.l_addr = la; v.l_wdata = ld; v.l_width = lwid;
        v.chk = 1'b1; v.e_stall = es; v.e_ack = ea; v.e_mre = er; v.e_mwe = ew;
        v.e_addr = eaddr; v.e_rvalid = erv; v.e_rdata = erd;
        return v;
    endfunction

    // One clock of stimulus: drive, compare against model (and table), advance.
    task automatic step(input vec_t v, input string tag);
        logic        gp, gl, stall, ack, mre, mwe, n_rvalid;
        logic [31:0] addr, wdata, n_rdata;
        logic [1:0]  wid;
        bit          n_forced;
        P_Req = v.p_req; P_Write = v.p_write; P_Addr = v.p_addr; P_WData = v.p_wdata; P_Width = v.p_width;
        L_Req = v.l_req; L_Write = v.l_write; L_Lock = v.l_lock; L_Addr = v.l_addr; L_WData = v.l_wdata;
        L_Width = v.l_width;
        #2;
        if (m_forced) begin
            gp = 1'b0; gl = v.l_req; stall = v.p_req;
        end else begin
            gp = v.p_req; gl = !v.p_req && v.l_req; stall = 1'b0;
        end
        ack = gl;
        mre = 1'b0; mwe = 1'b0; addr = 32'h0; wdata = 32'h0; wid = 2'b00;
        if (gp) begin
            mre = !v.p_write; mwe = v.p_write; addr = v.p_addr; wdata = v.p_wdata; wid = v.p_width;
        end else if (gl) begin
            mre = !v.l_write; mwe = v.l_write; addr = v.l_addr; wdata = v.l_wdata; wid = v.l_width;
        end
        check({tag, "_model_port"},
              128'({M_R_Enable, M_W_Enable, M_Addr, M_WData, M_R_Width, M_W_Width, P_Stall, L_Ack, P_RData}),
              128'({mre, mwe, addr, wdata, wid, wid, stall, ack, mem[addr[9:2]]}));
        check({tag, "_model_rdata"}, 128'({L_RValid, L_RData}), 128'({m_rvalid, m_rdata}));
        if (v.chk) begin
            check({tag, "_tbl_port"}, 128'({P_Stall, L_Ack, M_R_Enable, M_W_Enable, M_Addr}),
                  128'({v.e_stall, v.e_ack, v.e_mre, v.e_mwe, v.e_addr}));
            check({tag, "_tbl_rdata"}, 128'({L_RValid, L_RData}), 128'({v.e_rvalid, v.e_rdata}));
        end
        if (m_forced) begin
            n_forced = v.l_req && v.l_lock;
            m_losses = 0;
        end else if (v.p_req && v.l_req) begin
            m_losses++;
            n_forced = (m_losses >= MAX_WAIT);
            if (n_forced) m_losses = 0;
        end else begin
            n_forced = 1'b0;
            m_losses = 0;
        end
        if (gl && !v.l_write) begin
            n_rvalid = 1'b1; n_rdata = mem[v.l_addr[9:2]];
        end else begin
            n_rvalid = 1'b0; n_rdata = m_rdata;
        end
        @(posedge Clock);
        m_forced = n_forced; m_rvalid = n_rvalid; m_rdata = n_rdata;
        #1;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        Reset_n = 1'b0;
        P_Req = 1'b1; P_Write = 1'b1; P_Addr = 32'h10; P_WData = 32'hDEADBEEF; P_Width = WIDTH_WORD;
        L_Req = 1'b0; L_Write = 1'b0; L_Lock = 1'b0; L_Addr = 32'h0; L_WData = 32'h0; L_Width = WIDTH_WORD;
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8] <= 32'h12345678;
        model_reset();

        // Directed table: store, idle steal, starvation, burst, readback, abandoned lock.
        tbl.push_back(mk(1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b0,1'b1,32'h10, 1'b0,32'h0));
        tbl.push_back(mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h20,32'h0,WIDTH_WORD, 1'b0,1'b1,1'b1,1'b0,32'h20, 1'b0,32'h0));
        tbl.push_back(mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h12345678));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b0,32'h40,32'hA5,WIDTH_BYTE, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b0,32'h40,32'hA5,WIDTH_BYTE, 1'b1,1'b1,1'b0,1'b1,32'h40, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b0,32'h40,32'hA5,WIDTH_BYTE, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h12345678));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h40,32'h11,WIDTH_BYTE, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h40,32'h11,WIDTH_BYTE, 1'b1,1'b1,1'b0,1'b1,32'h40, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h41,32'h22,WIDTH_BYTE, 1'b1,1'b1,1'b0,1'b1,32'h41, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b0,32'h42,32'h33,WIDTH_BYTE, 1'b1,1'b1,1'b0,1'b1,32'h42, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h40,32'h0,WIDTH_WORD, 1'b0,1'b1,1'b1,1'b0,32'h40, 1'b0,32'h12345678));
        tbl.push_back(mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h00332211));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h50,32'h77,WIDTH_BYTE, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h00332211));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h50,32'h77,WIDTH_BYTE, 1'b1,1'b1,1'b0,1'b1,32'h50, 1'b0,32'h00332211));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h00332211));
        tbl.push_back(mk(1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h00332211));

        // Reset held with a pipeline store pending: nothing may reach memory.
        repeat (2) @(posedge Clock);
        #2;
        check("rst_enables", 128'({M_W_Enable, M_R_Enable}), 128'(2'b00));
        check("rst_stall_ack", 128'({P_Stall, L_Ack}), 128'(2'b00));
        check("rst_rdata", 128'({L_RValid, L_RData}), 128'(33'h0));
        Reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));
        check("store_commit", 128'(mem[4]), 128'(32'hDEADBEEF));
        check("abandon_byte", 128'(mem[20]), 128'(32'h00000077));

        // Reset during a locked loader burst: write must not land, pipeline owns after.
        for (int i = 0; i < 5; i++) begin
            rv = mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h5C,32'h88,WIDTH_BYTE, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0);
            rv.chk = 1'b0;
            step(rv, "mb_enter");
        end
        L_Addr = 32'h60; L_WData = 32'h99;
        #2;
        check("mb_locked_ack", 128'({L_Ack, M_W_Enable, P_Stall}), 128'(3'b111));
        Reset_n = 1'b0;
        #1;
        check("mb_rst_drop", 128'({M_R_Enable, M_W_Enable, L_Ack, P_Stall}), 128'(4'b0000));
        @(posedge Clock);
        #1;
        check("mb_no_write", 128'(mem[24]), 128'(32'h0));
        check("mb_prev_write", 128'(mem[23]), 128'(32'h00000088));
        Reset_n = 1'b1;
        model_reset();
        step(mk(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,1'b1,32'h60,32'h99,WIDTH_BYTE, 1'b0,1'b0,1'b1,1'b0,32'h100, 1'b0,32'h0), "mb_after");
        rv = mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,WIDTH_WORD, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0);
        rv.chk = 1'b0;
        step(rv, "mb_idle");

        // Random traffic against the model, including the reserved width code.
        for (int i = 0; i < 400; i++) begin
            rv.p_req   = ($urandom_range(0, 3) != 0);
            rv.p_write = $urandom_range(0, 1) == 1;
            rv.p_addr  = {22'h0, 10'($urandom_range(0, 1023))};
            rv.p_wdata = $urandom;
            rv.p_width = 2'($urandom_range(0, 3));
            rv.l_req   = ($urandom_range(0, 3) != 0);
            rv.l_write = $urandom_range(0, 1) == 1;
            rv.l_lock  = ($urandom_range(0, 2) == 0);
            rv.l_addr  = {22'h0, 10'($urandom_range(0, 1023))};
            rv.l_wdata = $urandom;
            rv.l_width = 2'($urandom_range(0, 3));
            rv.chk     = 1'b0;
            step(rv, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
